// File: rtl/boot_loader_if.sv
// Bus bundle between the UART byte receiver, the loader and instruction memory.
// The master modport is the environment side (receiver + core status);
// the slave modport is the boot_loader itself.
interface boot_loader_if #(
   parameter int ADDR_W = 8
);
   // Byte handshake: the receiver raises packet_ready with uart_packet stable
   // and holds both until it has seen packet_ack high for one cycle; the byte
   // is taken on the clock edge that ends the ack cycle. packet_ack is a
   // single-cycle pulse and is never high on two consecutive cycles.
   logic              cpu_halted;
   logic              packet_ready;
   logic [7:0]        uart_packet;
   logic              packet_ack;
   logic              load_active;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              load_done;
   logic              load_error;
   logic [3:0]        dbg_state;

   modport master (
      output cpu_halted, packet_ready, uart_packet,
      input  packet_ack, load_active, mem_we, mem_addr, mem_wdata,
             load_done, load_error, dbg_state
   );

   modport slave (
      input  cpu_halted, packet_ready, uart_packet,
      output packet_ack, load_active, mem_we, mem_addr, mem_wdata,
             load_done, load_error, dbg_state
   );
endinterface

// File: rtl/boot_loader.sv
// UART boot loader: receives a framed program image byte by byte and writes
// it as 16-bit words into instruction memory while the core is halted.
// Frame: SYNC_BYTE, length hi, length lo, N x (data hi, data lo) [, checksum].
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing checksum byte;
// the 8-bit sum of every byte after the sync byte must come out as 8'h00.
module boot_loader #(
   parameter int          ADDR_W        = 8,
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
   parameter int          TIMEOUT_TICKS = 1_000_000
) (
   input logic           clk,
   input logic           rst,
   boot_loader_if.slave  bus
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_LEN_HI  = 4'd1;
   localparam logic [3:0] S_LEN_LO  = 4'd2;
   localparam logic [3:0] S_DATA_HI = 4'd3;
   localparam logic [3:0] S_DATA_LO = 4'd4;
   localparam logic [3:0] S_WRITE   = 4'd5;
   localparam logic [3:0] S_CHECK   = 4'd6;
   localparam logic [3:0] S_DONE    = 4'd7;
   localparam logic [3:0] S_ERROR   = 4'd8;

   localparam int          TMR_W     = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS + 1);
   // Largest legal word count: the whole memory, 2^ADDR_W words.
   localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

   logic [3:0]        r_state;
   logic [3:0]        w_next;
   logic              r_ack;
   logic [7:0]        r_len_hi;
   logic [15:0]       r_count;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [15:0]       r_mem_wdata;
   logic              r_done;
   logic              r_error;
   logic [TMR_W-1:0]  r_timer;

   logic              w_consume;
   logic [7:0]        w_byte;
   logic              w_active;
   logic              w_accepting;
   logic              w_timeout;
   logic              w_halt_lost;
   logic              w_abort;
   logic              w_start;
   logic [15:0]       w_len;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        r_csum;
   logic [7:0]        w_csum_next;
   assign w_csum_next = r_csum + w_byte;
`endif

   // The byte on uart_packet is taken during the cycle packet_ack is high.
   assign w_consume   = r_ack;
   assign w_byte      = bus.uart_packet;
   assign w_active    = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
   assign w_timeout   = w_active && (r_timer >= TMR_W'(TIMEOUT_TICKS - 1));
   assign w_halt_lost = w_active && !bus.cpu_halted;
   // An abort overrides any byte consumed in the same cycle.
   assign w_abort     = w_timeout || w_halt_lost;
   assign w_start     = (r_state == S_IDLE) && w_consume && (w_byte == SYNC_BYTE) && bus.cpu_halted;
   assign w_len       = {r_len_hi, w_byte};

   // Only ack in states that take a byte, so nothing is lost during WRITE/CHECK/DONE/ERROR.
   always_comb begin
      w_accepting = 1'b0;
      case (r_state)
         S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: w_accepting = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         S_CHECK: w_accepting = 1'b1;
`endif
         default: w_accepting = 1'b0;
      endcase
   end

   // Next-state decode for the frame parser.
   always_comb begin
      w_next = r_state;
      if (w_abort) begin
         w_next = S_ERROR;
      end else begin
         case (r_state)
            S_IDLE:    if (w_start) w_next = S_LEN_HI;
            S_LEN_HI:  if (w_consume) w_next = S_LEN_LO;
            S_LEN_LO: begin
               if (w_consume) begin
                  if (w_len == 16'd0)
                     w_next = S_CHECK;
                  else if ({17'd0, w_len} > MAX_WORDS)
                     w_next = S_ERROR;
                  else
                     w_next = S_DATA_HI;
               end
            end
            S_DATA_HI: if (w_consume) w_next = S_DATA_LO;
            S_DATA_LO: if (w_consume) w_next = S_WRITE;
            S_WRITE:   w_next = (r_count == 16'd1) ? S_CHECK : S_DATA_HI;
            S_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
               if (w_consume) w_next = (w_csum_next == 8'h00) ? S_DONE : S_ERROR;
`else
               w_next = S_DONE;
`endif
            end
            S_DONE:    w_next = S_IDLE;
            S_ERROR:   w_next = S_IDLE;
            default:   w_next = S_IDLE;
         endcase
      end
   end

   // State register and the single-cycle ack pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ack   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ack   <= bus.packet_ready && !r_ack && w_accepting;
      end
   end

   // Inter-byte timer: cleared by each consumed byte and whenever no frame is open.
   always_ff @(posedge clk) begin
      if (rst || !w_active || w_consume)
         r_timer <= '0;
      else
         r_timer <= r_timer + TMR_W'(1);
   end

   // Length, data word, address and remaining-count datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_len_hi    <= 8'd0;
         r_count     <= 16'd0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 16'd0;
      end else if (!w_abort) begin
         case (r_state)
            S_IDLE:    if (w_start) r_mem_addr <= '0;
            S_LEN_HI:  if (w_consume) r_len_hi <= w_byte;
            S_LEN_LO:  if (w_consume) r_count <= w_len;
            S_DATA_HI: if (w_consume) r_mem_wdata[15:8] <= w_byte;
            S_DATA_LO: if (w_consume) r_mem_wdata[7:0] <= w_byte;
            S_WRITE: begin
               // Address wraps naturally after a full-memory image.
               r_mem_addr <= r_mem_addr + ADDR_W'(1);
               r_count    <= r_count - 16'd1;
            end
            default: ;
         endcase
      end
   end

   // Sticky result flags, cleared only when a new frame starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else if (w_start) begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else if (r_state == S_DONE) begin
         r_done  <= 1'b1;
      end else if (r_state == S_ERROR) begin
         r_error <= 1'b1;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // Running sum of every byte after the sync byte, checksum byte included.
   always_ff @(posedge clk) begin
      if (rst || w_start)
         r_csum <= 8'd0;
      else if (w_active && w_consume && !w_abort)
         r_csum <= w_csum_next;
   end
`endif

   assign bus.packet_ack  = r_ack;
   assign bus.load_active = w_active;
   assign bus.mem_we      = (r_state == S_WRITE);
   assign bus.mem_addr    = r_mem_addr;
   assign bus.mem_wdata   = r_mem_wdata;
   assign bus.load_done   = r_done;
   assign bus.load_error  = r_error;
   assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: byte driver, write scoreboard, and one
// task per scenario. Memory writes are matched against an expected queue
// filled as data bytes are sent.
module tb_boot_loader;
   localparam int AW  = 8;
   localparam int TMO = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   boot_loader_if #(.ADDR_W(AW)) bus ();

   boot_loader #(
      .ADDR_W(AW),
      .SYNC_BYTE(8'hA5),
      .TIMEOUT_TICKS(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   logic [AW+15:0] exp_q[$];
   logic [15:0]    words[$];
   int             n_cmp  = 0;
   int             n_err  = 0;
   int             n_acks = 0;
   logic           prev_ack = 1'b0;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]     csum_delta = 8'd0;
`endif

   // Write scoreboard and ack-pulse monitor, sampled mid-cycle.
   always @(negedge clk) begin
      logic [AW+15:0] exp_w;
      if (bus.mem_we === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write: got addr=%0h data=%0h, expected no write", bus.mem_addr, bus.mem_wdata);
         end else begin
            exp_w = exp_q.pop_front();
            if ({bus.mem_addr, bus.mem_wdata} !== exp_w) begin
               n_err++;
               $display("FAIL mem_write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                        bus.mem_addr, bus.mem_wdata, exp_w[AW+15:16], exp_w[15:0]);
            end
         end
      end
      if (bus.packet_ack === 1'b1) begin
         n_acks++;
         n_cmp++;
         if (prev_ack === 1'b1) begin
            n_err++;
            $display("FAIL ack_pulse: got ack high two cycles in a row, expected single-cycle pulse");
         end
      end
      prev_ack = bus.packet_ack;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      bit got;
      got = 1'b0;
      bus.uart_packet  = b;
      bus.packet_ready = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); #1;
         if (bus.packet_ack === 1'b1) got = 1'b1;
      end
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL ack_wait: got no ack for byte %0h, expected ack within 20 cycles", b);
      end else begin
         @(posedge clk); #1;
      end
      bus.packet_ready = 1'b0;
   endtask

   // Sends sync, length and the words queue; pushes the expected writes.
   task automatic send_frame();
      logic [15:0] n;
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] s;
`endif
      n = 16'(words.size());
      send_byte(8'hA5);
      send_byte(n[15:8]);
      send_byte(n[7:0]);
`ifdef LOADER_CHECKSUM_EN
      s = n[15:8] + n[7:0];
`endif
      for (int i = 0; i < words.size(); i++) begin
         exp_q.push_back({AW'(i), words[i]});
         send_byte(words[i][15:8]);
         send_byte(words[i][7:0]);
`ifdef LOADER_CHECKSUM_EN
         s = s + words[i][15:8] + words[i][7:0];
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'h00 - s + csum_delta);
`endif
   endtask

   // Polls for either sticky flag; cyc = -1 if none within limit cycles.
   task automatic wait_status(input int limit, output int cyc);
      cyc = -1;
      for (int i = 1; i <= limit && cyc < 0; i++) begin
         @(posedge clk); #1;
         if (bus.load_done === 1'b1 || bus.load_error === 1'b1) cyc = i;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.cpu_halted   = 1'b1;
      bus.packet_ready = 1'b0;
      bus.uart_packet  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (bus.packet_ack  !== 1'b0)  begin n_err++; $display("FAIL rst_ack: got %b, expected 0", bus.packet_ack); end
      n_cmp++; if (bus.load_active !== 1'b0)  begin n_err++; $display("FAIL rst_active: got %b, expected 0", bus.load_active); end
      n_cmp++; if (bus.mem_we      !== 1'b0)  begin n_err++; $display("FAIL rst_we: got %b, expected 0", bus.mem_we); end
      n_cmp++; if (bus.mem_addr    !== '0)    begin n_err++; $display("FAIL rst_addr: got %0h, expected 0", bus.mem_addr); end
      n_cmp++; if (bus.mem_wdata   !== 16'd0) begin n_err++; $display("FAIL rst_wdata: got %0h, expected 0", bus.mem_wdata); end
      n_cmp++; if (bus.load_done   !== 1'b0)  begin n_err++; $display("FAIL rst_done: got %b, expected 0", bus.load_done); end
      n_cmp++; if (bus.load_error  !== 1'b0)  begin n_err++; $display("FAIL rst_error: got %b, expected 0", bus.load_error); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_frame();
      int cyc;
      words = '{16'h1234, 16'hABCD};
      send_frame();
      wait_status(40, cyc);
      n_cmp++; if (cyc < 0) begin n_err++; $display("FAIL basic_wait: got no status flag, expected load_done"); end
      n_cmp++; if (bus.load_done  !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b, expected 1", bus.load_done); end
      n_cmp++; if (bus.load_error !== 1'b0) begin n_err++; $display("FAIL basic_error: got %b, expected 0", bus.load_error); end
      n_cmp++; if (bus.load_active !== 1'b0) begin n_err++; $display("FAIL basic_active: got %b, expected 0", bus.load_active); end
      n_cmp++; if (bus.mem_addr !== AW'(2)) begin n_err++; $display("FAIL basic_addr: got %0h, expected 2", bus.mem_addr); end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL basic_writes: got %0d missing writes, expected 0", exp_q.size()); end
   endtask

   task automatic test_check_stage();
`ifdef LOADER_CHECKSUM_EN
      int cyc;
      csum_delta = 8'd1;
      words = '{16'h1234, 16'hABCD};
      send_frame();
      csum_delta = 8'd0;
      wait_status(40, cyc);
      n_cmp++; if (bus.load_error !== 1'b1) begin n_err++; $display("FAIL csum_error: got %b, expected 1", bus.load_error); end
      n_cmp++; if (bus.load_done  !== 1'b0) begin n_err++; $display("FAIL csum_done: got %b, expected 0", bus.load_done); end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL csum_writes: got %0d missing writes, expected 0", exp_q.size()); end
`else
      // No checksum byte: a stray trailing byte is discarded in IDLE.
      send_byte(8'h0E);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (bus.load_done  !== 1'b1) begin n_err++; $display("FAIL trail_done: got %b, expected 1", bus.load_done); end
      n_cmp++; if (bus.load_error !== 1'b0) begin n_err++; $display("FAIL trail_error: got %b, expected 0", bus.load_error); end
      n_cmp++; if (bus.dbg_state  !== 4'd0) begin n_err++; $display("FAIL trail_state: got %0d, expected 0", bus.dbg_state); end
`endif
   endtask

   task automatic test_not_halted();
      logic [7:0] seq [5];
      int a0;
      seq = '{8'hA5, 8'h00, 8'h01, 8'hFF, 8'hFF};
      bus.cpu_halted = 1'b0;
      a0 = n_acks;
      for (int i = 0; i < 5; i++) begin
         send_byte(seq[i]);
         n_cmp++;
         if (bus.load_active !== 1'b0) begin n_err++; $display("FAIL nohalt_active: got %b, expected 0", bus.load_active); end
      end
      n_cmp++; if (n_acks - a0 != 5) begin n_err++; $display("FAIL nohalt_acks: got %0d, expected 5", n_acks - a0); end
      bus.cpu_halted = 1'b1;
   endtask

   task automatic test_timeout();
      int cyc;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
      exp_q.push_back({AW'(0), 16'h1122});
      send_byte(8'h11); send_byte(8'h22);
      wait_status(TMO + 20, cyc);
      n_cmp++; if (cyc < TMO || cyc > TMO + 2) begin n_err++; $display("FAIL tmo_cycles: got %0d, expected %0d..%0d", cyc, TMO, TMO + 2); end
      n_cmp++; if (bus.load_error !== 1'b1) begin n_err++; $display("FAIL tmo_error: got %b, expected 1", bus.load_error); end
      n_cmp++; if (bus.load_done  !== 1'b0) begin n_err++; $display("FAIL tmo_done: got %b, expected 0", bus.load_done); end
      words = '{16'h5566};
      send_frame();
      wait_status(40, cyc);
      n_cmp++; if (bus.load_done !== 1'b1) begin n_err++; $display("FAIL tmo_restart_done: got %b, expected 1", bus.load_done); end
      n_cmp++; if (bus.mem_addr !== AW'(1)) begin n_err++; $display("FAIL tmo_restart_addr: got %0h, expected 1", bus.mem_addr); end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL tmo_writes: got %0d missing writes, expected 0", exp_q.size()); end
   endtask

   task automatic test_halt_loss();
      int cyc;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
      exp_q.push_back({AW'(0), 16'h0102});
      send_byte(8'h01); send_byte(8'h02);
      bus.cpu_halted = 1'b0;
      wait_status(10, cyc);
      n_cmp++; if (cyc < 0 || cyc > 3) begin n_err++; $display("FAIL halt_cycles: got %0d, expected 1..3", cyc); end
      n_cmp++; if (bus.load_error !== 1'b1) begin n_err++; $display("FAIL halt_error: got %b, expected 1", bus.load_error); end
      n_cmp++; if (bus.load_done  !== 1'b0) begin n_err++; $display("FAIL halt_done: got %b, expected 0", bus.load_done); end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL halt_writes: got %0d missing writes, expected 0", exp_q.size()); end
      bus.cpu_halted = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_len_overflow();
      int cyc;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
      wait_status(10, cyc);
      n_cmp++; if (bus.load_error !== 1'b1) begin n_err++; $display("FAIL ovf_error: got %b, expected 1", bus.load_error); end
      n_cmp++; if (bus.load_done  !== 1'b0) begin n_err++; $display("FAIL ovf_done: got %b, expected 0", bus.load_done); end
      n_cmp++; if (bus.load_active !== 1'b0) begin n_err++; $display("FAIL ovf_active: got %b, expected 0", bus.load_active); end
   endtask

   task automatic test_sync_in_data();
      int cyc;
      words = '{16'hA5A5, 16'h00A5};
      send_frame();
      wait_status(40, cyc);
      n_cmp++; if (bus.load_done !== 1'b1) begin n_err++; $display("FAIL syncdata_done: got %b, expected 1", bus.load_done); end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL syncdata_writes: got %0d missing writes, expected 0", exp_q.size()); end
   endtask

   task automatic test_max_len();
      int cyc;
      words.delete();
      for (int i = 0; i < (1 << AW); i++) words.push_back(16'($urandom_range(0, 65535)));
      send_frame();
      wait_status(40, cyc);
      n_cmp++; if (bus.load_done !== 1'b1) begin n_err++; $display("FAIL max_done: got %b, expected 1", bus.load_done); end
      n_cmp++; if (bus.load_error !== 1'b0) begin n_err++; $display("FAIL max_error: got %b, expected 0", bus.load_error); end
      n_cmp++; if (bus.mem_addr !== '0) begin n_err++; $display("FAIL max_addr_wrap: got %0h, expected 0", bus.mem_addr); end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL max_writes: got %0d missing writes, expected 0", exp_q.size()); end
   endtask

   task automatic test_reset_midframe();
      int cyc;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (bus.packet_ack  !== 1'b0)  begin n_err++; $display("FAIL mid_rst_ack: got %b, expected 0", bus.packet_ack); end
      n_cmp++; if (bus.load_active !== 1'b0)  begin n_err++; $display("FAIL mid_rst_active: got %b, expected 0", bus.load_active); end
      n_cmp++; if (bus.mem_we      !== 1'b0)  begin n_err++; $display("FAIL mid_rst_we: got %b, expected 0", bus.mem_we); end
      n_cmp++; if (bus.mem_addr    !== '0)    begin n_err++; $display("FAIL mid_rst_addr: got %0h, expected 0", bus.mem_addr); end
      n_cmp++; if (bus.mem_wdata   !== 16'd0) begin n_err++; $display("FAIL mid_rst_wdata: got %0h, expected 0", bus.mem_wdata); end
      n_cmp++; if (bus.load_done   !== 1'b0)  begin n_err++; $display("FAIL mid_rst_done: got %b, expected 0", bus.load_done); end
      n_cmp++; if (bus.load_error  !== 1'b0)  begin n_err++; $display("FAIL mid_rst_error: got %b, expected 0", bus.load_error); end
      rst = 1'b0;
      @(posedge clk); #1;
      words.delete();
      send_frame();
      wait_status(20, cyc);
      n_cmp++; if (bus.load_done  !== 1'b1) begin n_err++; $display("FAIL zero_len_done: got %b, expected 1", bus.load_done); end
      n_cmp++; if (bus.load_error !== 1'b0) begin n_err++; $display("FAIL zero_len_error: got %b, expected 0", bus.load_error); end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_check_stage();
      test_not_halted();
      test_timeout();
      test_halt_loss();
      test_len_overflow();
      test_sync_in_data();
      test_max_len();
      test_reset_midframe();
      repeat (5) @(posedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL final_queue: got %0d pending writes, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
